// File: rtl/median_pkg.sv
// Shared types and defaults for the 3x3 median front-end.
`timescale 1ns/1ps
package median_pkg;

   typedef enum logic [1:0] {
      S_IDLE,
      S_HBLANK,
      S_ACTIVE
   } state_t;

   localparam int DEF_IMG_WIDTH   = 640;
   localparam int DEF_IMG_HEIGHT  = 480;
   localparam int MEDIAN_PIPE_LAT = 3;

endpackage

// File: rtl/median_line_buf.sv
// Simple dual-port line RAM: combinational read of old contents, write on clock edge.
// Latency 0 on read, 1 on write; no backpressure.
`timescale 1ns/1ps
module median_line_buf #(
   parameter int DEPTH  = 640,
   parameter int DATA_W = 8,
   parameter int ADDR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
   input  logic              clk,
   input  logic              wr_en,
   input  logic [ADDR_W-1:0] wr_addr,
   input  logic [DATA_W-1:0] wr_dat,
   input  logic [ADDR_W-1:0] rd_addr,
   output logic [DATA_W-1:0] rd_dat
);

   logic [DATA_W-1:0] mem [DEPTH];

   always_ff @(posedge clk) begin
      if (wr_en) mem[wr_addr] <= wr_dat;
   end

   assign rd_dat = mem[rd_addr];

endmodule

// File: rtl/median_window_ctrl.sv
// Raster sequencer building the 3x3 window, border and line-error flags for the median filter.
// Latency: outputs one cycle after the accepted clken; no backpressure, paced by per_frame_clken.
`timescale 1ns/1ps
module median_window_ctrl
   import median_pkg::*;
#(
   parameter int IMG_WIDTH  = DEF_IMG_WIDTH,
   parameter int IMG_HEIGHT = DEF_IMG_HEIGHT,
   parameter int DATA_W     = 8
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              per_frame_vsync,
   input  logic              per_frame_href,
   input  logic              per_frame_clken,
   input  logic [DATA_W-1:0] per_img_y,
   output logic              matrix_frame_vsync,
   output logic              matrix_frame_href,
   output logic              matrix_frame_clken,
   output logic [DATA_W-1:0] matrix_p11,
   output logic [DATA_W-1:0] matrix_p12,
   output logic [DATA_W-1:0] matrix_p13,
   output logic [DATA_W-1:0] matrix_p21,
   output logic [DATA_W-1:0] matrix_p22,
   output logic [DATA_W-1:0] matrix_p23,
   output logic [DATA_W-1:0] matrix_p31,
   output logic [DATA_W-1:0] matrix_p32,
   output logic [DATA_W-1:0] matrix_p33,
   output logic              matrix_border,
   output logic              line_err
);

   localparam int COL_W  = $clog2(IMG_WIDTH + 1);
   localparam int ROW_W  = $clog2(IMG_HEIGHT);
   localparam int ADDR_W = (IMG_WIDTH > 1) ? $clog2(IMG_WIDTH) : 1;
   localparam logic [COL_W-1:0] COL_MAX = COL_W'(IMG_WIDTH);
   localparam logic [COL_W-1:0] COL_TWO = COL_W'(2);
   localparam logic [ROW_W-1:0] ROW_MAX = ROW_W'(IMG_HEIGHT - 1);
   localparam logic [ROW_W-1:0] ROW_TWO = ROW_W'(2);

   state_t            state, state_nxt;
   logic              vsync_d, href_d, armed;
   logic              vsync_rise, vsync_fall, href_rise, href_fall;
   logic [COL_W-1:0]  col_cnt;
   logic [ROW_W-1:0]  row_cnt;
   logic              excess_seen;
   logic              accept, excess, frame_start, line_start, line_end, err_nxt;
   logic [DATA_W-1:0] lba_rd, lbb_rd;
   logic [ADDR_W-1:0] addr;

   // armed blocks a false vsync rise when reset releases in the middle of a frame
   assign vsync_rise = per_frame_vsync & ~vsync_d & armed;
   assign vsync_fall = ~per_frame_vsync & vsync_d;
   assign href_rise  = per_frame_href & ~href_d;
   assign href_fall  = ~per_frame_href & href_d;

   assign matrix_frame_vsync = vsync_d;
   assign matrix_frame_href  = href_d;
   assign addr               = col_cnt[ADDR_W-1:0];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= S_IDLE;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt   = state;
      accept      = 1'b0;
      excess      = 1'b0;
      frame_start = 1'b0;
      line_start  = 1'b0;
      line_end    = 1'b0;
      err_nxt     = 1'b0;
      case (state)
         S_IDLE: begin
            if (vsync_rise) begin
               state_nxt   = S_HBLANK;
               frame_start = 1'b1;
            end
         end
         S_HBLANK: begin
            if (vsync_fall) begin
               state_nxt = S_IDLE;
            end else if (href_rise) begin
               state_nxt  = S_ACTIVE;
               line_start = 1'b1;
            end
         end
         S_ACTIVE: begin
            if (vsync_fall) begin
               state_nxt = S_IDLE;
               err_nxt   = 1'b1;
            end else if (href_fall) begin
               state_nxt = S_HBLANK;
               line_end  = 1'b1;
               err_nxt   = (col_cnt != COL_MAX);
            end
            if (per_frame_clken) begin
               if (col_cnt < COL_MAX) begin
                  accept = 1'b1;
               end else if (!excess_seen) begin
                  excess  = 1'b1;
                  err_nxt = 1'b1;
               end
            end
         end
         default: state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         vsync_d            <= 1'b0;
         href_d             <= 1'b0;
         armed              <= 1'b0;
         row_cnt            <= '0;
         col_cnt            <= '0;
         excess_seen        <= 1'b0;
         matrix_frame_clken <= 1'b0;
         matrix_border      <= 1'b0;
         line_err           <= 1'b0;
      end else begin
         vsync_d            <= per_frame_vsync;
         href_d             <= per_frame_href;
         armed              <= armed | ~per_frame_vsync;
         if (frame_start)
            row_cnt <= '0;
         else if (line_end && row_cnt != ROW_MAX)
            row_cnt <= row_cnt + 1'b1;
         if (line_start)  col_cnt <= '0;
         else if (accept) col_cnt <= col_cnt + 1'b1;
         if (line_start)  excess_seen <= 1'b0;
         else if (excess) excess_seen <= 1'b1;
         matrix_frame_clken <= accept;
         matrix_border      <= accept & ((row_cnt < ROW_TWO) | (col_cnt < COL_TWO));
         line_err           <= err_nxt;
      end
   end

   // Row masking keeps stale line-buffer data off the taps for the first two rows
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n || line_start) begin
         if (!rst_n) begin
            matrix_p11 <= '0; matrix_p12 <= '0; matrix_p13 <= '0;
            matrix_p21 <= '0; matrix_p22 <= '0; matrix_p23 <= '0;
            matrix_p31 <= '0; matrix_p32 <= '0; matrix_p33 <= '0;
         end else begin
            matrix_p11 <= '0; matrix_p12 <= '0; matrix_p13 <= '0;
            matrix_p21 <= '0; matrix_p22 <= '0; matrix_p23 <= '0;
            matrix_p31 <= '0; matrix_p32 <= '0; matrix_p33 <= '0;
         end
      end else if (accept) begin
         matrix_p11 <= matrix_p12;
         matrix_p12 <= matrix_p13;
         matrix_p13 <= (row_cnt < ROW_TWO) ? '0 : lbb_rd;
         matrix_p21 <= matrix_p22;
         matrix_p22 <= matrix_p23;
         matrix_p23 <= (row_cnt == '0) ? '0 : lba_rd;
         matrix_p31 <= matrix_p32;
         matrix_p32 <= matrix_p33;
         matrix_p33 <= per_img_y;
      end
   end

   median_line_buf #(
      .DEPTH  (IMG_WIDTH),
      .DATA_W (DATA_W),
      .ADDR_W (ADDR_W)
   ) u_lba (
      .clk     (clk),
      .wr_en   (accept),
      .wr_addr (addr),
      .wr_dat  (per_img_y),
      .rd_addr (addr),
      .rd_dat  (lba_rd)
   );

   median_line_buf #(
      .DEPTH  (IMG_WIDTH),
      .DATA_W (DATA_W),
      .ADDR_W (ADDR_W)
   ) u_lbb (
      .clk     (clk),
      .wr_en   (accept),
      .wr_addr (addr),
      .wr_dat  (lba_rd),
      .rd_addr (addr),
      .rd_dat  (lbb_rd)
   );

endmodule

// File: tb/tb_median_window_ctrl.sv
// Bench for median_window_ctrl at 4x4: directed frame sequence with random pixels and line lengths.
`timescale 1ns/1ps
module tb_median_window_ctrl;

   localparam int W = 4;
   localparam int H = 4;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       vsync, href, clken;
   logic [7:0] y;
   logic       m_vsync, m_href, m_clken, border, line_err;
   logic [7:0] p11, p12, p13, p21, p22, p23, p31, p32, p33;
   logic [71:0] win;
   logic [76:0] all_out;

   int total  = 0;
   int passed = 0;

   // reference model state: frame row count, per-column write history, current line
   int          mdl_row;
   int          hist_col[$];
   logic [7:0]  hist_val[$];
   logic [7:0]  cur_pix[8];
   logic [7:0]  cur_a[8];
   logic [7:0]  cur_b[8];
   logic [71:0] obs_win[8];
   logic        obs_brd[8];

   always #5 clk = ~clk;

   assign win     = {p11, p12, p13, p21, p22, p23, p31, p32, p33};
   assign all_out = {m_vsync, m_href, m_clken, border, line_err, win};

   median_window_ctrl #(
      .IMG_WIDTH  (W),
      .IMG_HEIGHT (H),
      .DATA_W     (8)
   ) dut (
      .clk                (clk),
      .rst_n              (rst_n),
      .per_frame_vsync    (vsync),
      .per_frame_href     (href),
      .per_frame_clken    (clken),
      .per_img_y          (y),
      .matrix_frame_vsync (m_vsync),
      .matrix_frame_href  (m_href),
      .matrix_frame_clken (m_clken),
      .matrix_p11         (p11),
      .matrix_p12         (p12),
      .matrix_p13         (p13),
      .matrix_p21         (p21),
      .matrix_p22         (p22),
      .matrix_p23         (p23),
      .matrix_p31         (p31),
      .matrix_p32         (p32),
      .matrix_p33         (p33),
      .matrix_border      (border),
      .line_err           (line_err)
   );

   task automatic step;
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [76:0] obs, input logic [76:0] exp);
      total++;
      assert (obs === exp) passed++;
      else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
   endtask

   // window = three most recent pixels of this line, with the previous and second-previous
   // values ever written to each column above them, zeroed where the row count masks them
   task automatic model_pixel(input int c, input logic [7:0] v,
                              output logic [71:0] ew, output logic eb);
      int         found;
      logic [7:0] a, b;
      found = 0;
      a = 8'h00;
      b = 8'h00;
      for (int i = hist_col.size() - 1; i >= 0; i--) begin
         if (found < 2 && hist_col[i] == c) begin
            if (found == 0) a = hist_val[i];
            else            b = hist_val[i];
            found++;
         end
      end
      cur_pix[c] = v;
      cur_a[c]   = a;
      cur_b[c]   = b;
      hist_col.push_back(c);
      hist_val.push_back(v);
      ew = '0;
      for (int k = 0; k < 3; k++) begin
         int cc;
         cc = c - 2 + k;
         if (cc >= 0) begin
            ew[71-8*k -: 8] = (mdl_row < 2) ? 8'h00 : cur_b[cc];
            ew[47-8*k -: 8] = (mdl_row < 1) ? 8'h00 : cur_a[cc];
            ew[23-8*k -: 8] = cur_pix[cc];
         end
      end
      eb = (mdl_row < 2) || (c < 2);
   endtask

   task automatic accept_pixel(input int c, input logic [7:0] v);
      logic [71:0] ew;
      logic        eb;
      y = v;
      clken = 1'b1;
      step;
      model_pixel(c, v, ew, eb);
      obs_win[c] = win;
      obs_brd[c] = border;
      check("win_clken", 77'(m_clken), 77'(1));
      check("window", 77'(win), 77'(ew));
      check("border", 77'(border), 77'(eb));
      check("err_quiet", 77'(line_err), 77'(0));
   endtask

   // mode 0: pixel = row*16+col, mode 1: constant 0xFF, otherwise random
   task automatic run_line(input int len, input int mode, input int tag_row);
      logic [7:0] v;
      href = 1'b1;
      clken = 1'b0;
      step;
      check("lead_clken", 77'(m_clken), 77'(0));
      for (int c = 0; c < len; c++) begin
         case (mode)
            0:       v = 8'(tag_row * 16 + c);
            1:       v = 8'hFF;
            default: v = 8'($urandom);
         endcase
         if (c < W) begin
            accept_pixel(c, v);
         end else begin
            y = v;
            clken = 1'b1;
            step;
            check("excess_clken", 77'(m_clken), 77'(0));
            check("excess_err", 77'(line_err), 77'(c == W));
         end
      end
      clken = 1'b0;
      href = 1'b0;
      step;
      check("eol_err", 77'(line_err), 77'(len < W));
      if (mdl_row < H - 1) mdl_row++;
      step;
      check("err_pulse_end", 77'(line_err), 77'(0));
   endtask

   task automatic frame_start;
      vsync = 1'b1;
      href = 1'b0;
      clken = 1'b0;
      mdl_row = 0;
      step;
      step;
   endtask

   task automatic frame_end;
      vsync = 1'b0;
      step;
      step;
   endtask

   initial begin
      rst_n = 1'b0;
      vsync = 1'b0;
      href = 1'b0;
      clken = 1'b0;
      y = 8'h00;
      mdl_row = 0;

      for (int i = 0; i < 6; i++) begin
         vsync = 1'($urandom);
         href  = 1'($urandom);
         clken = 1'($urandom);
         y     = 8'($urandom);
         step;
         check("reset_outputs", all_out, 77'(0));
      end
      vsync = 1'b0;
      href = 1'b0;
      clken = 1'b0;
      step;
      rst_n = 1'b1;
      step;

      href = 1'b1;
      for (int i = 0; i < 5; i++) begin
         clken = 1'b1;
         y = 8'($urandom);
         step;
         check("pre_vsync_clken", 77'(m_clken), 77'(0));
      end
      href = 1'b0;
      clken = 1'b0;
      step;

      frame_start;
      run_line(4, 0, 0);
      check("row0_col3_win", 77'(obs_win[3]), 77'(72'h000000_000000_010203));
      check("row0_col3_border", 77'(obs_brd[3]), 77'(1));
      run_line(4, 0, 1);
      check("row1_col1_top", 77'(obs_win[1][71:48]), 77'(0));
      check("row1_col1_border", 77'(obs_brd[1]), 77'(1));
      run_line(4, 0, 2);
      check("row2_col2_win", 77'(obs_win[2]), 77'(72'h000102_101112_202122));
      check("row2_col2_border", 77'(obs_brd[2]), 77'(0));
      run_line(3, 0, 3);
      run_line(5, 0, 4);
      run_line(4, 0, 5);
      check("after_long_mid", 77'(obs_win[3][47:24]), 77'(24'h414243));
      frame_end;

      frame_start;
      run_line(4, 1, 0);
      check("f2_row0_mask", 77'(obs_win[3]), 77'(72'h000000_000000_FFFFFF));
      run_line(4, 1, 1);
      check("f2_row1_mask", 77'(obs_win[3]), 77'(72'h000000_FFFFFF_FFFFFF));
      run_line($urandom_range(2, 6), 2, 0);
      run_line($urandom_range(2, 6), 2, 0);

      href = 1'b1;
      clken = 1'b0;
      step;
      accept_pixel(0, 8'($urandom));
      accept_pixel(1, 8'($urandom));
      rst_n = 1'b0;
      #1;
      check("midline_reset", all_out, 77'(0));
      step;
      check("midline_reset_hold", all_out, 77'(0));
      rst_n = 1'b1;
      for (int i = 0; i < 4; i++) begin
         y = 8'($urandom);
         step;
         check("post_reset_clken", 77'(m_clken), 77'(0));
         check("post_reset_err", 77'(line_err), 77'(0));
      end
      href = 1'b0;
      clken = 1'b0;
      frame_end;

      frame_start;
      run_line(4, 2, 0);
      run_line(4, 2, 1);
      for (int l = 0; l < 4; l++) run_line($urandom_range(2, 6), 2, 0);
      href = 1'b1;
      step;
      accept_pixel(0, 8'($urandom));
      clken = 1'b0;
      vsync = 1'b0;
      step;
      check("vsync_fall_err", 77'(line_err), 77'(1));
      href = 1'b0;
      step;
      check("idle_href_fall", 77'(line_err), 77'(0));
      step;

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
